// File: rtl/bus2mem_pkg.sv
// Shared widths and FSM state type for the bus-to-memory write path.
package bus2mem_pkg;
  localparam int BUS_W_DEF  = 512;  // default bus word width
  localparam int ADDR_W_DEF = 20;   // default memory word-address width
  localparam int CNT_W      = 16;   // packet counters / cfg_num_pkt
  localparam int IDX_W      = 32;   // per-job word counters

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/bus2mem_fifo.sv
// Single-clock first-word-fall-through word buffer with full/empty/free-count.
// Push while full is accepted when a pop happens in the same cycle.
module bus2mem_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   free_cnt
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, used;

  assign used     = wr_ptr - rd_ptr;
  assign empty    = (used == '0);
  assign full     = (used == (AW+1)'(DEPTH));
  assign free_cnt = (AW+1)'(DEPTH) - used;
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  // pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write; contents need no reset, empty gates the head downstream
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/bus2mem_wr.sv
// Bus-to-memory writer: buffers decoded bus words and streams them to memory
// at consecutive word addresses from a configured base, counting packets.
// Optional overflow flag built only when BUS2MEM_WR_OVF_CHK_EN is defined.
module bus2mem_wr
  import bus2mem_pkg::*;
#(
  parameter int BUS_W         = BUS_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int WORDS_PER_PKT = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk_bus,
  input  logic              rst,
  input  logic [BUS_W-1:0]  bus_data,
  input  logic              bus_en,
  output logic              bus_ready,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_num_pkt,
  input  logic              cfg_start,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [BUS_W-1:0]  mem_wr_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              done,
  output logic              ovf_err
);
  localparam int FAW = $clog2(FIFO_DEPTH);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] base_q, word_idx;
  logic [IDX_W-1:0]  total_q, push_cnt;
  logic [CNT_W-1:0]  beat_q;
  logic              start, push, pop, fifo_full, fifo_empty;
  logic [FAW:0]      free_cnt;
  logic [FAW+1:0]    free_nxt;
  logic [BUS_W-1:0]  fifo_head;

  // cfg_start is only honoured between jobs
  assign start = cfg_start && ((state == IDLE) || (state == DONE));
  assign pop   = !fifo_empty && mem_wr_ready;
  assign push  = (state == RUN) && bus_en && (!fifo_full || pop);

  bus2mem_fifo #(.W(BUS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk_bus),
    .rst      (rst),
    .push     (push),
    .wr_data  (bus_data),
    .pop      (pop),
    .rd_data  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .free_cnt (free_cnt)
  );

  assign mem_wr_valid = !fifo_empty;
  assign mem_wr_data  = fifo_empty ? '0 : fifo_head;
  assign mem_wr_addr  = base_q + word_idx;
  assign done         = (state == DONE);

  // occupancy after this edge, so bus_ready reflects the registered state it lands with
  assign free_nxt = (FAW+2)'(free_cnt) + (FAW+2)'(pop) - (FAW+2)'(push);

  // state register
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state: RUN until the job's last word is buffered, DRAIN until empty
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (push && (push_cnt == total_q - 1)) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // job configuration and word/packet counters
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      total_q  <= '0;
      push_cnt <= '0;
      word_idx <= '0;
      beat_q   <= '0;
      pkt_cnt  <= '0;
    end else if (start) begin
      base_q   <= cfg_base_addr;
      total_q  <= IDX_W'(cfg_num_pkt) * IDX_W'(WORDS_PER_PKT);
      push_cnt <= '0;
      word_idx <= '0;
      beat_q   <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (push) push_cnt <= push_cnt + 1'b1;
      if (pop) begin
        word_idx <= word_idx + 1'b1;
        if (beat_q == CNT_W'(WORDS_PER_PKT - 1)) begin
          beat_q  <= '0;
          pkt_cnt <= pkt_cnt + 1'b1;
        end else begin
          beat_q  <= beat_q + 1'b1;
        end
      end
    end
  end

  // one-packet-plus-one margin covers the upstream response latency
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) bus_ready <= 1'b0;
    else     bus_ready <= (state_nxt == RUN) && (free_nxt >= (FAW+2)'(WORDS_PER_PKT + 1));
  end

`ifdef BUS2MEM_WR_OVF_CHK_EN
  logic ovf_q;
  // sticky drop flag; a drop in the start cycle wins over the clear
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst)                 ovf_q <= 1'b0;
    else if (bus_en && !push) ovf_q <= 1'b1;
    else if (start)          ovf_q <= 1'b0;
  end
  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif
endmodule

// File: tb/tb_bus2mem_wr.sv
// Randomized bench for bus2mem_wr with a queue-based reference model.
module tb_bus2mem_wr;
  localparam int BW = 512, AW = 20, WPP = 2, DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
  localparam int NOSTOP = 32'h7fffffff;
`ifdef BUS2MEM_WR_OVF_CHK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk_bus = 1'b0, rst = 1'b1;
  logic [BW-1:0] bus_data = '0;
  logic          bus_en = 1'b0, bus_ready;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [15:0]   cfg_num_pkt = '0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] mem_wr_addr;
  logic [BW-1:0] mem_wr_data;
  logic          mem_wr_valid, mem_wr_ready = 1'b0;
  logic [15:0]   pkt_cnt;
  logic          done, ovf_err;

  logic [31:0] w_data = '0;
  logic        w_en = 1'b0, w_bready, w_start = 1'b0, w_valid, w_ready = 1'b1;
  logic [3:0]  w_base = '0, w_addr;
  logic [15:0] w_num = '0, w_pkt;
  logic [31:0] w_wdata;
  logic        w_done, w_ovf;

  always #5 clk_bus = ~clk_bus;

  bus2mem_wr #(.BUS_W(BW), .ADDR_W(AW), .WORDS_PER_PKT(WPP), .FIFO_DEPTH(DEPTH)) dut (
    .clk_bus(clk_bus), .rst(rst), .bus_data(bus_data), .bus_en(bus_en), .bus_ready(bus_ready),
    .cfg_base_addr(cfg_base_addr), .cfg_num_pkt(cfg_num_pkt), .cfg_start(cfg_start),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready), .pkt_cnt(pkt_cnt), .done(done), .ovf_err(ovf_err));

  bus2mem_wr #(.BUS_W(32), .ADDR_W(4), .WORDS_PER_PKT(WPP), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk_bus(clk_bus), .rst(rst), .bus_data(w_data), .bus_en(w_en), .bus_ready(w_bready),
    .cfg_base_addr(w_base), .cfg_num_pkt(w_num), .cfg_start(w_start),
    .mem_wr_addr(w_addr), .mem_wr_data(w_wdata), .mem_wr_valid(w_valid),
    .mem_wr_ready(w_ready), .pkt_cnt(w_pkt), .done(w_done), .ovf_err(w_ovf));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] rnd();
    logic [BW-1:0] r;
    for (int i = 0; i < BW/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // reference model: pending words in a queue, job progress as plain counters
  logic [BW-1:0] q[$];
  logic [AW-1:0] obs_addr[$];
  logic [AW-1:0] m_base = '0;
  int m_mode = M_IDLE, m_total = 0, m_pushed = 0, m_widx = 0, m_pkt = 0, m_writes = 0;
  bit m_ovf = 0, m_bready = 0;

  always @(negedge clk_bus) begin
    int occ, mode0;
    bit pop, push;
    logic [AW-1:0] ea;
    if (rst) begin
      q.delete();
      m_mode = M_IDLE; m_widx = 0; m_pkt = 0; m_ovf = 0; m_bready = 0; m_pushed = 0;
      chk("rst_valid", mem_wr_valid, 0);
      chk("rst_addr", mem_wr_addr, 0);
      chk("rst_data", mem_wr_data, 0);
      chk("rst_bready", bus_ready, 0);
      chk("rst_pkt", pkt_cnt, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf_err, 0);
    end else begin
      occ = q.size();
      mode0 = m_mode;
      ea = m_base + AW'(m_widx);
      chk("wr_valid", mem_wr_valid, occ > 0);
      if (occ > 0) begin
        chk("wr_addr", mem_wr_addr, ea);
        chk("wr_data", mem_wr_data, q[0]);
      end
      chk("bus_ready", bus_ready, m_bready);
      chk("pkt_cnt", pkt_cnt, m_pkt);
      chk("done", done, m_mode == M_DONE);
      chk("ovf_err", ovf_err, m_ovf);
      pop  = (occ > 0) && mem_wr_ready;
      push = (m_mode == M_RUN) && bus_en && ((occ < DEPTH) || pop);
      if (bus_en && !push && OVF_EN) m_ovf = 1;
      if (pop) begin
        obs_addr.push_back(mem_wr_addr);
        void'(q.pop_front());
        m_widx++; m_writes++;
        if (m_widx % WPP == 0) m_pkt++;
      end
      if (push) begin
        q.push_back(bus_data);
        m_pushed++;
      end
      if (m_mode == M_RUN && push && m_pushed == m_total) m_mode = M_DRAIN;
      else if (m_mode == M_DRAIN && occ == 0) m_mode = M_DONE;
      if (cfg_start && (mode0 == M_IDLE || mode0 == M_DONE)) begin
        m_base = cfg_base_addr; m_total = int'(cfg_num_pkt) * WPP;
        m_pushed = 0; m_widx = 0; m_pkt = 0; m_ovf = 0; m_mode = M_RUN;
      end
      m_bready = (m_mode == M_RUN) && (DEPTH - q.size() >= WPP + 1);
    end
  end

  // handshake log for the narrow-address instance
  logic [3:0]  wobs_a[$];
  logic [31:0] wobs_d[$], wexp_d[$];
  always @(negedge clk_bus) begin
    if (!rst && w_valid && w_ready) begin
      wobs_a.push_back(w_addr);
      wobs_d.push_back(w_wdata);
    end
  end

  task automatic step();
    @(posedge clk_bus); #1;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input int n);
    cfg_base_addr = b; cfg_num_pkt = 16'(n); cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  // upstream: starts a packet only when bus_ready is seen, then sends its words back to back
  task automatic feed(input int nw, input int stop_w);
    int sent = 0, cyc = 0;
    while (sent < nw && m_writes < stop_w && cyc < 3000) begin
      if (bus_ready && $urandom_range(0, 3) != 0) begin
        for (int k = 0; k < WPP && sent < nw && m_writes < stop_w; k++) begin
          bus_en = 1'b1; bus_data = rnd(); step(); sent++; cyc++;
        end
        bus_en = 1'b0;
      end else begin
        step(); cyc++;
      end
    end
    if (cyc >= 3000) chk("feed_timeout", sent, nw);
  endtask

  task automatic wait_done();
    int c = 0;
    while (!done && c < 500) begin step(); c++; end
    chk("done_wait", done, 1);
  endtask

  initial begin
    int w0;
    bit seen_low;
    repeat (3) @(posedge clk_bus);
    #1 rst = 1'b0;
    step();

    // basic job
    mem_wr_ready = 1'b1;
    obs_addr.delete();
    start_job(20'h100, 3);
    feed(6, NOSTOP);
    wait_done();
    chk("basic_nwr", obs_addr.size(), 6);
    for (int i = 0; i < 6 && i < obs_addr.size(); i++) chk("basic_addr", obs_addr[i], 20'h100 + i);
    chk("basic_pkt", pkt_cnt, 3);

    // stray word while DONE is dropped
    bus_en = 1'b1; bus_data = rnd(); step(); bus_en = 1'b0;
    chk("ovf_done_state", ovf_err, OVF_EN);

    // back-to-back job from DONE
    obs_addr.delete();
    start_job(20'h3000, 2);
    chk("b2b_done", done, 0);
    chk("b2b_pkt", pkt_cnt, 0);
    chk("b2b_ovf", ovf_err, 0);
    feed(4, NOSTOP);
    wait_done();
    if (obs_addr.size() > 0) chk("b2b_addr0", obs_addr[0], 20'h3000);
    chk("b2b_pkt_end", pkt_cnt, 2);

    // backpressure: memory stalls for 20 cycles
    mem_wr_ready = 1'b0;
    seen_low = 1'b0;
    start_job(20'h200, 3);
    fork
      feed(6, NOSTOP);
      begin
        repeat (20) begin
          step();
          if (q.size() >= 2 && !bus_ready) seen_low = 1'b1;
        end
        mem_wr_ready = 1'b1;
      end
    join
    wait_done();
    chk("bp_ready_low", seen_low, 1);
    chk("bp_ovf", ovf_err, 0);
    chk("bp_pkt", pkt_cnt, 3);

    // overflow: six forced words into a stalled 4-deep buffer
    mem_wr_ready = 1'b0;
    start_job(20'h400, 4);
    repeat (6) begin bus_en = 1'b1; bus_data = rnd(); step(); end
    bus_en = 1'b0;
    chk("ovf_flag", ovf_err, OVF_EN);
    chk("ovf_full_valid", mem_wr_valid, 1);
    mem_wr_ready = 1'b1;
    feed(4, NOSTOP);
    wait_done();
    chk("ovf_pkt", pkt_cnt, 4);
    chk("ovf_sticky", ovf_err, OVF_EN);

    // reset after three writes of a six-word job
    start_job(20'h500, 3);
    w0 = m_writes;
    feed(6, w0 + 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", mem_wr_valid, 0);
    chk("mid_rst_addr", mem_wr_addr, 0);
    chk("mid_rst_data", mem_wr_data, 0);
    chk("mid_rst_bready", bus_ready, 0);
    chk("mid_rst_pkt", pkt_cnt, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("post_rst_valid", mem_wr_valid, 0);
    obs_addr.delete();
    start_job(20'h600, 2);
    feed(4, NOSTOP);
    wait_done();
    chk("clean_nwr", obs_addr.size(), 4);
    if (obs_addr.size() > 0) chk("clean_addr0", obs_addr[0], 20'h600);
    chk("clean_pkt", pkt_cnt, 2);

    // address wrap on the 4-bit-address instance
    w_base = 4'hE; w_num = 16'd2; w_start = 1'b1;
    step();
    w_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_en = 1'b1; w_data = $urandom(); wexp_d.push_back(w_data); step();
    end
    w_en = 1'b0;
    begin
      int c = 0;
      while (!w_done && c < 200) begin step(); c++; end
    end
    chk("wrap_done", w_done, 1);
    chk("wrap_nwr", wobs_a.size(), 4);
    for (int i = 0; i < 4 && i < wobs_a.size(); i++) begin
      logic [3:0] ea;
      ea = 4'hE + 4'(i);
      chk("wrap_addr", wobs_a[i], ea);
      chk("wrap_data", wobs_d[i], wexp_d[i]);
    end
    chk("wrap_pkt", w_pkt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
